// File: rtl/gpio_irq_port_if.sv
// Bus control bundle for the GPIO port: word address plus read/write strobes.
// Latency: none, plain wires.
// Backpressure: none, the slave always accepts a strobe in the cycle it is presented.
interface gpio_irq_port_if;
  logic [63:0] address;
  logic        write;
  logic        read;

  modport master (output address, output write, output read);
  modport slave  (input  address, input  write, input  read);
endinterface

// File: rtl/gpio_irq_port.sv
// GPIO port with per-pin direction, set/clear, and edge-detect interrupt status.
// Latency: reads combinational; writes land on the strobe edge; a pin edge reaches STATUS/irq two edges after s1.
// Backpressure: none; every strobe is accepted, and the shared data bus is tri-stated unless a readable register is read.
module gpio_irq_port #(
  parameter int          WIDTH = 64,
  parameter logic [63:0] BASE  = 64'h0000000000000000
) (
  input  logic             clock,
  input  logic             reset,
  gpio_irq_port_if.slave   bus,
  // The tri-state nets stay at the module boundary so each pad has one obvious driver point.
  inout  wire  [63:0]      data,
  inout  wire  [WIDTH-1:0] pins,
  output logic             irq
);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_REN  = 3'd5;
  localparam logic [2:0] A_FEN  = 3'd6;
  localparam logic [2:0] A_STAT = 3'd7;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;

  logic [63:0]      w_off;
  logic             w_hit;
  logic [2:0]       w_idx;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_rd_en;
  logic [63:0]      w_rd_dat;

  // Offset wraps for addresses below BASE, so one unsigned compare rejects both sides.
  assign w_off  = bus.address - BASE;
  assign w_hit  = (w_off < 64'd8);
  assign w_idx  = w_off[2:0];
  assign w_wr   = bus.write & w_hit;
  assign w_wdat = data[WIDTH-1:0];

  // Edge detect compares the synchronised sample against the one before it.
  assign w_set  = (r_s2 & ~r_prev & r_rise_en) | (~r_s2 & r_prev & r_fall_en);
  assign w_clr  = (w_wr && (w_idx == A_STAT)) ? w_wdat : '0;

  assign irq    = |r_status;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pad
      assign pins[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
    end
  endgenerate

  assign data = w_rd_en ? w_rd_dat : 64'bz;

  // Read mux: combinational from current state, upper bits zero-filled.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_dat = '0;
    if (bus.read && w_hit) begin
      case (w_idx)
        A_OUT:   begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_out;     end
        A_DIR:   begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_dir;     end
        A_IN:    begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_s2;      end
        A_REN:   begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_rise_en; end
        A_FEN:   begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_fall_en; end
        A_STAT:  begin w_rd_en = 1'b1; w_rd_dat[WIDTH-1:0] = r_status;  end
        default: begin w_rd_en = 1'b0; end
      endcase
    end
  end

  // Pin synchroniser plus the history flop used for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= pins;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Writable control registers; OUTSET/OUTCLR fold into OUT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_idx)
        A_OUT:   r_out     <= w_wdat;
        A_DIR:   r_dir     <= w_dir_next(w_wdat);
        A_SET:   r_out     <= r_out | w_wdat;
        A_CLR:   r_out     <= r_out & ~w_wdat;
        A_REN:   r_rise_en <= w_wdat;
        A_FEN:   r_fall_en <= w_wdat;
        default: r_out     <= r_out;
      endcase
    end
  end

  function automatic logic [WIDTH-1:0] w_dir_next(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  // Sticky status: clear-on-write-1 first, then new edges OR in so a set wins a tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

endmodule
